fanout_valid_fork: RTL and testbench



---
 rtl/fanout_valid_fork.sv | 100 ++++++++++
 tb/tb_fanout_valid_fork.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_valid_fork.sv
// Eager ready/valid fork: one upstream stream broadcast to NUM_OUT sinks, each sink sees each token once.
// Optional delivered-token counter enabled by defining FANOUT_FORK_STATS_EN.
`timescale 1ns/1ps

module fanout_valid_fork #(
  parameter int unsigned NUM_OUT    = 6,
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_OUT-1:0]    out_en,
  input  logic [NUM_OUT-1:0]    out_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready
`ifdef FANOUT_FORK_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  tok_count
`endif
);

  typedef enum logic [0:0] {StEmpty, StHold} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_OUT-1:0]    pending_q;

  logic                  full;
  logic [NUM_OUT-1:0]    active;
  logic [NUM_OUT-1:0]    ack;
  logic                  done;
  logic                  load;

  always_comb begin
    full      = (state_q == StHold);
    active    = out_en & out_sel;
    out_valid = {NUM_OUT{full}} & pending_q;
    out_data  = data_q;
    ack       = out_valid & out_ready;
    done      = full & ((pending_q & ~ack) == '0);
    // Ready passes straight through from the sinks so a fully accepted token frees the slot
    // in the same cycle.
    in_ready  = ~flush & (~full | done);
    load      = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      data_q    <= '0;
      pending_q <= '0;
    end else if (flush) begin
      state_q   <= StEmpty;
      pending_q <= '0;
    end else if (load) begin
      data_q <= in_data;
      // Routes are sampled only here; later config changes leave the held token alone.
      if (active != '0) begin
        pending_q <= active;
        state_q   <= StHold;
      end else begin
        pending_q <= '0;
        state_q   <= StEmpty;
      end
    end else begin
      unique case (state_q)
        StHold: begin
          pending_q <= pending_q & ~ack;
          if (done) begin
            state_q <= StEmpty;
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

`ifdef FANOUT_FORK_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // A flush in the same cycle wins, so that token is not counted as delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (done && !flush) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign tok_count = cnt_q;
`endif

endmodule

// File: tb/tb_fanout_valid_fork.sv
// Self-checking bench for fanout_valid_fork: directed scenarios plus randomized traffic
// checked against a token-level reference model.
`timescale 1ns/1ps

module tb_fanout_valid_fork;

  localparam int unsigned NumOut = 6;
  localparam int unsigned DataW  = 17;
  localparam int unsigned CntW   = 32;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [DataW-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NumOut-1:0] out_en;
  logic [NumOut-1:0] out_sel;
  logic [DataW-1:0]  out_data;
  logic [NumOut-1:0] out_valid;
  logic [NumOut-1:0] out_ready;
`ifdef FANOUT_FORK_STATS_EN
  logic [CntW-1:0]   tok_count;
`endif

  int checks;
  int failures;

  fanout_valid_fork #(
    .NUM_OUT   (NumOut),
    .DATA_WIDTH(DataW),
    .CNT_WIDTH (CntW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_en   (out_en),
    .out_sel  (out_sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef FANOUT_FORK_STATS_EN
    ,
    .tok_count(tok_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a held token, the set of sinks still owed it, and a delivered count.
  logic              m_has_tok;
  logic [DataW-1:0]  m_data;
  logic [NumOut-1:0] m_owed;
  int unsigned       m_delivered;

  function automatic void mdl_reset();
    m_has_tok   = 1'b0;
    m_data      = '0;
    m_owed      = '0;
    m_delivered = 0;
  endfunction

  function automatic logic [NumOut-1:0] exp_valid();
    return m_has_tok ? m_owed : '0;
  endfunction

  // Slot is free if nothing is held or every sink still owed is taking it now.
  function automatic logic exp_ready();
    logic slot_free;
    slot_free = !m_has_tok || ((m_owed & ~out_ready) == '0);
    return !flush && slot_free;
  endfunction

  function automatic void mdl_clock();
    logic fully_taken;
    logic accept;
    fully_taken = m_has_tok && ((m_owed & ~out_ready) == '0);
    accept      = in_valid && exp_ready();
    if (!rst_n) begin
      mdl_reset();
    end else if (flush) begin
      m_has_tok = 1'b0;
      m_owed    = '0;
    end else begin
      if (fully_taken) m_delivered++;
      if (accept) begin
        m_data    = in_data;
        m_owed    = out_en & out_sel;
        m_has_tok = (m_owed != '0);
      end else if (m_has_tok) begin
        m_owed    = m_owed & ~out_ready;
        m_has_tok = (m_owed != '0);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    mdl_clock();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DataW-1:0] d, input logic [NumOut-1:0] rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_en = '0; out_sel = '0; out_ready = '0;
    mdl_reset();
    #1;
    checks++;
    if (out_valid !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h want 0/0", out_valid, out_data);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== '0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b want 1/000000", in_ready, out_valid);
    end
`ifdef FANOUT_FORK_STATS_EN
    checks++;
    if (tok_count !== '0) begin
      failures++;
      $display("FAIL reset_count: got %0d want 0", tok_count);
    end
`endif
  endtask

  task automatic test_streaming();
    out_en = 6'b111111; out_sel = 6'b000101;
    for (int k = 1; k <= 5; k++) begin
      drive(k <= 4, DataW'(k), 6'b111111);
      if (k <= 4) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_ready%0d: got %b want 1", k, in_ready);
        end
      end
      if (k >= 2) begin
        checks++;
        if (out_valid !== 6'b000101 || out_data !== DataW'(k - 1)) begin
          failures++;
          $display("FAIL stream_out%0d: got valid=%b data=%h want 000101/%h",
                   k, out_valid, out_data, DataW'(k - 1));
        end
      end
      tick();
    end
    drive(1'b0, '0, '0);
    checks++;
    if (out_valid !== '0) begin
      failures++;
      $display("FAIL stream_drained: got %b want 000000", out_valid);
    end
`ifdef FANOUT_FORK_STATS_EN
    checks++;
    if (tok_count !== CntW'(4)) begin
      failures++;
      $display("FAIL stream_count: got %0d want 4", tok_count);
    end
`endif
  endtask

  task automatic test_staggered();
    logic [NumOut-1:0] want_v [4] = '{6'b000011, 6'b000010, 6'b000010, 6'b000000};
    logic              want_r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [NumOut-1:0] rdy    [4] = '{6'b000001, 6'b000001, 6'b000010, 6'b000000};
    out_en = 6'b111111; out_sel = 6'b000011;
    drive(1'b1, 17'h1ABCD, '0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, rdy[c]);
      checks++;
      if (out_valid !== want_v[c] || in_ready !== want_r[c]) begin
        failures++;
        $display("FAIL stagger_c%0d: got valid=%b ready=%b want %b/%b",
                 c + 1, out_valid, in_ready, want_v[c], want_r[c]);
      end
      tick();
    end
  endtask

  task automatic test_empty_route();
    out_en = 6'b111111; out_sel = 6'b000000;
    drive(1'b1, 17'h00055, '0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== '0) begin
      failures++;
      $display("FAIL empty_load: got ready=%b valid=%b want 1/000000", in_ready, out_valid);
    end
    tick();
    drive(1'b0, '0, '0);
    checks++;
    if (out_valid !== '0 || in_ready !== 1'b1 || out_data !== 17'h00055) begin
      failures++;
      $display("FAIL empty_after: got valid=%b ready=%b data=%h want 000000/1/00055",
               out_valid, in_ready, out_data);
    end
`ifdef FANOUT_FORK_STATS_EN
    checks++;
    if (tok_count !== CntW'(m_delivered)) begin
      failures++;
      $display("FAIL empty_count: got %0d want %0d", tok_count, m_delivered);
    end
`endif
    tick();
  endtask

  task automatic test_config_hold();
    out_en = 6'b111111; out_sel = 6'b000001;
    drive(1'b1, 17'h0A0A0, '0);
    tick();
    out_sel = 6'b100000;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, '0);
      checks++;
      if (out_valid !== 6'b000001 || out_data !== 17'h0A0A0) begin
        failures++;
        $display("FAIL cfg_hold%0d: got valid=%b data=%h want 000001/0a0a0",
                 c, out_valid, out_data);
      end
      tick();
    end
    drive(1'b1, 17'h0B0B0, 6'b000001);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL cfg_release: got ready=%b want 1", in_ready);
    end
    tick();
    drive(1'b0, '0, '0);
    checks++;
    if (out_valid !== 6'b100000 || out_data !== 17'h0B0B0) begin
      failures++;
      $display("FAIL cfg_next: got valid=%b data=%h want 100000/0b0b0", out_valid, out_data);
    end
    drive(1'b0, '0, 6'b111111);
    tick();
  endtask

  task automatic test_flush();
    int unsigned cnt_before;
    out_en = 6'b111111; out_sel = 6'b000110;
    drive(1'b1, 17'h0F00D, '0);
    tick();
    cnt_before = m_delivered;
    flush = 1'b1;
    drive(1'b1, 17'h12345, '0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 6'b000110) begin
      failures++;
      $display("FAIL flush_cycle: got ready=%b valid=%b want 0/000110", in_ready, out_valid);
    end
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    checks++;
    if (out_valid !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_after: got valid=%b ready=%b want 000000/1", out_valid, in_ready);
    end
`ifdef FANOUT_FORK_STATS_EN
    checks++;
    if (tok_count !== CntW'(cnt_before)) begin
      failures++;
      $display("FAIL flush_count: got %0d want %0d", tok_count, cnt_before);
    end
`endif
  endtask

  task automatic test_async_reset();
    out_en = 6'b111111; out_sel = 6'b000011;
    drive(1'b1, 17'h1CAFE, '0);
    tick();
    drive(1'b0, '0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b data=%h want 000000/00000", out_valid, out_data);
    end
`ifdef FANOUT_FORK_STATS_EN
    checks++;
    if (tok_count !== '0) begin
      failures++;
      $display("FAIL async_count: got %0d want 0", tok_count);
    end
`endif
    tick();
    rst_n = 1'b1;
    out_sel = 6'b000001;
    drive(1'b1, 17'h00777, '0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== '0) begin
      failures++;
      $display("FAIL async_first: got ready=%b valid=%b want 1/000000", in_ready, out_valid);
    end
    tick();
    drive(1'b0, '0, 6'b111111);
    checks++;
    if (out_valid !== 6'b000001 || out_data !== 17'h00777) begin
      failures++;
      $display("FAIL async_load: got valid=%b data=%h want 000001/00777", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0) begin
        out_en  = NumOut'($urandom);
        out_sel = ($urandom_range(7) == 0) ? '0 : NumOut'($urandom);
      end
      flush = ($urandom_range(15) == 0);
      drive($urandom_range(1), DataW'($urandom), NumOut'($urandom | $urandom));
      checks++;
      if (out_valid !== exp_valid() || in_ready !== exp_ready() || out_data !== m_data) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_c%0d: got valid=%b ready=%b data=%h want %b/%b/%h",
                   c, out_valid, in_ready, out_data, exp_valid(), exp_ready(), m_data);
      end
`ifdef FANOUT_FORK_STATS_EN
      checks++;
      if (tok_count !== CntW'(m_delivered)) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_count_c%0d: got %0d want %0d", c, tok_count, m_delivered);
      end
`endif
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_streaming();
    test_staggered();
    test_empty_route();
    test_config_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
